fc3l_pwm_modulator: RTL

- Phase-shifted PWM modulator for the two interleaved three-level flying-capacitor (3LFCC) legs.
- Sits downstream of the control loop that consumes the ADS1115 readings from the two I2C buses.
- Turns one duty command per leg into the eight gate signals on `pwm_o`: per leg, two switch cells with complementary pairs and dead time.
- Duty commands are double-buffered and applied only at carrier wrap, so a pulse is never truncated.

---
 rtl/fc3l_pkg.sv | 18 +
 rtl/fc3l_dead_time.sv | 90 +++++++++
 rtl/fc3l_pwm_modulator.sv | 114 +++++++++++
 3 files changed

// File: rtl/fc3l_pkg.sv
// Shared definitions for the 3LFCC phase-shifted PWM modulator.
// Gate bit positions within one leg and the dead-time generator states.
package fc3l_pkg;

  localparam int S1    = 0;
  localparam int S1C   = 1;
  localparam int S2    = 2;
  localparam int S2C   = 3;
  localparam int LEG_W = 4;

  typedef enum logic [1:0] {
    DT_IDLE_OFF,
    DT_ON_MAIN,
    DT_ON_COMP,
    DT_DEAD
  } dt_state_t;

endpackage

// File: rtl/fc3l_dead_time.sv
// Dead-time generator: one raw gate in, registered main/complement pair out.
// Ports: clk, rst_n (async low), en, raw -> main, comp.
module fc3l_dead_time
  import fc3l_pkg::*;
#(
  parameter int DEAD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic raw,
  output logic main,
  output logic comp
);

  localparam int DW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
  localparam logic [DW-1:0] LOAD = DW'(DEAD);
  localparam logic [DW-1:0] ONE  = DW'(1);

  dt_state_t state, state_n;
  dt_state_t go_state;
  logic [DW-1:0] dcnt, dcnt_n;
  logic tgt, tgt_n;

  // With no dead time a raw change switches sides directly.
  assign go_state = (DEAD == 0)
                  ? (raw ? DT_ON_MAIN : DT_ON_COMP)
                  : DT_DEAD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DT_IDLE_OFF;
      dcnt  <= '0;
      tgt   <= 1'b0;
    end else begin
      state <= state_n;
      dcnt  <= dcnt_n;
      tgt   <= tgt_n;
    end
  end

  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    tgt_n   = tgt;
    if (!en) begin
      state_n = DT_IDLE_OFF;
    end else begin
      unique case (state)
        DT_IDLE_OFF: begin
          state_n = go_state;
          dcnt_n  = LOAD;
          tgt_n   = raw;
        end
        DT_ON_MAIN: begin
          if (!raw) begin
            state_n = go_state;
            dcnt_n  = LOAD;
            tgt_n   = raw;
          end
        end
        DT_ON_COMP: begin
          if (raw) begin
            state_n = go_state;
            dcnt_n  = LOAD;
            tgt_n   = raw;
          end
        end
        DT_DEAD: begin
          // tgt is the side we are heading for; a raw
          // change restarts the full dead interval.
          if (raw != tgt) begin
            dcnt_n = LOAD;
            tgt_n  = raw;
          end else if (dcnt <= ONE) begin
            state_n = tgt ? DT_ON_MAIN : DT_ON_COMP;
          end else begin
            dcnt_n = dcnt - ONE;
          end
        end
      endcase
    end
  end

  always_comb begin
    main = (state == DT_ON_MAIN);
    comp = (state == DT_ON_COMP);
  end

endmodule

// File: rtl/fc3l_pwm_modulator.sv
// Phase-shifted PWM for two interleaved 3-level flying-cap legs.
// Ports: clk_i, rst_ni, enable_i, duty0_i, duty1_i, duty_valid_i -> pwm_o[7:0], period_tick_o.
module fc3l_pwm_modulator
  import fc3l_pkg::*;
#(
  parameter int PERIOD = 270,
  parameter int CNT_W  = 9,
  parameter int DEAD   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] duty0_i,
  input  logic [CNT_W-1:0] duty1_i,
  input  logic             duty_valid_i,
  output logic [7:0]       pwm_o,
  output logic             period_tick_o
);

  localparam int XW = CNT_W + 1;
  localparam int Q  = PERIOD / 4;
  localparam int H  = PERIOD / 2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] PMAX = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] INC  = CNT_W'(1);
  localparam logic [XW-1:0]    PERX = XW'(PERIOD);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] sh0, sh1;
  logic [CNT_W-1:0] ac0, ac1;
  logic             wrap;
  logic [3:0]       raw, main, comp;

  function automatic logic [CNT_W-1:0] sat(
    input logic [CNT_W-1:0] d
  );
    return (d > PMAX) ? PMAX : d;
  endfunction

  assign wrap = enable_i && (cnt == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt           <= '0;
      period_tick_o <= 1'b0;
    end else begin
      period_tick_o <= wrap;
      if (!enable_i || wrap) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + INC;
      end
    end
  end

  // Shadow takes the command; active follows only at wrap
  // (or freely while stopped) so pulses are never cut short.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh0 <= '0;
      sh1 <= '0;
      ac0 <= '0;
      ac1 <= '0;
    end else begin
      if (duty_valid_i) begin
        sh0 <= sat(duty0_i);
        sh1 <= sat(duty1_i);
      end
      if (!enable_i || wrap) begin
        ac0 <= sh0;
        ac1 <= sh1;
      end
    end
  end

  // Cell c: leg c/2, S1 (c even) or S2 (c odd).
  for (genvar c = 0; c < 4; c++) begin : g_cell
    localparam int OFF = ((c % 2 == 1) ? H : 0)
                       + ((c / 2 == 1) ? Q : 0);
    localparam logic [XW-1:0] OFFX = XW'(OFF);

    logic [XW-1:0]    sum;
    logic [XW-1:0]    ph;
    logic [CNT_W-1:0] duty;

    assign duty = (c < 2) ? ac0 : ac1;
    assign sum  = {1'b0, cnt} + OFFX;
    assign ph   = (sum >= PERX) ? (sum - PERX) : sum;
    assign raw[c] = ph < {1'b0, duty};

    fc3l_dead_time #(
      .DEAD(DEAD)
    ) u_dt (
      .clk  (clk_i),
      .rst_n(rst_ni),
      .en   (enable_i),
      .raw  (raw[c]),
      .main (main[c]),
      .comp (comp[c])
    );
  end

  always_comb begin
    pwm_o = '0;
    for (int l = 0; l < 2; l++) begin
      pwm_o[l*LEG_W + S1]  = main[2*l];
      pwm_o[l*LEG_W + S1C] = comp[2*l];
      pwm_o[l*LEG_W + S2]  = main[2*l+1];
      pwm_o[l*LEG_W + S2C] = comp[2*l+1];
    end
  end

endmodule
